dmem_bus_bridge: RTL and testbench
==================================

Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the data-memory stage. Consumes its address, store data and byte-write-enable outputs, and supplies the load-data word back to that stage's read-data input.
- Routes each access by address bit 31:
  - 0 → on-chip synchronous data RAM, single cycle.
  - 1 → slow peripheral bus using a req/ack handshake. The pipeline is stalled until the handshake completes.
- Returns read data with a fixed one-cycle latency in both cases, so the upstream load-formatting logic is unchanged.

Parameters:
- RAM_AW, 12, word-address width of on-chip RAM (RAM = 4·2^RAM_AW bytes).
- TIMEOUT_CYC, 255, cycles to wait for pb_ack_i before abort (used only with the optional feature).
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr_i  in  32  byte address from the memory stage.
- wdata_i  in  32  store data, already lane-replicated.
- wr_en_i  in  4  byte write enables; bit 3 = byte 0 (big-endian lanes).
- rd_i  in  1  load in progress this cycle.
- rdata_o  out  32  read word, valid the cycle after the access completes.
- stall_o  out  1  freeze pipeline; inputs are held stable while high.
- ram_addr_o  out  RAM_AW  word address = addr_i[RAM_AW+1:2].
- ram_we_o  out  4  RAM byte write enables.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, one cycle after address.
- pb_req_o  out  1  peripheral request.
- pb_we_o  out  1  1 = write.
- pb_addr_o  out  32  latched address.
- pb_be_o  out  4  latched byte enables.
- pb_wdata_o  out  32  latched write data.
- pb_rdata_i  in  32  peripheral read data, sampled when ack is high.
- pb_ack_i  in  1  one-cycle completion strobe.
- err_o  out  1  timeout pulse; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset values (rst low, asynchronous):
  - state = IDLE.
  - pb_req_o, pb_we_o, pb_addr_o, pb_be_o, pb_wdata_o = 0.
  - rdata_q = 0, sel_q = 0, counter = 0, err_o = 0.
  - stall_o = 0. rdata_o = ram_rdata_i, because sel_q = 0.
- RAM path (addr_i[31] = 0):
  - Combinational pass-through: ram_addr_o, ram_wdata_o = wdata_i, ram_we_o = wr_en_i.
  - No stall.
- RAM write gating: ram_we_o is forced to 0 when addr_i[31] = 1, when stall_o = 1, or in DONE.
- Peripheral access definition: pacc = addr_i[31] & (rd_i | |wr_en_i).
- FSM states: IDLE, REQ, DONE.
  - IDLE:
    - If pacc: latch addr/be/wdata, set pb_we_o = |wr_en_i, assert pb_req_o next cycle, go to REQ.
    - stall_o = pacc, combinational.
  - REQ:
    - stall_o = 1. pb_req_o and the latched fields are held stable until ack.
    - On pb_ack_i: rdata_q ← pb_rdata_i (for writes too), drop pb_req_o, go to DONE.
  - DONE:
    - stall_o = 0 for exactly one cycle, letting the held instruction advance.
    - pacc is ignored in this cycle (no re-trigger). Return to IDLE.
- Read select register sel_q:
  - Updated every cycle with stall_o = 0: sel_q ← addr_i[31]. Held otherwise.
  - rdata_o = sel_q ? rdata_q : ram_rdata_i.
  - Result: a peripheral read word appears in the cycle after DONE.
- Earliest ack is one cycle after pb_req_o rises. pb_ack_i is ignored in IDLE and DONE (stale acks are dropped).
- Back-to-back peripheral accesses: DONE → IDLE → new request. Minimum 3 cycles per access with an immediate ack.
- Mixed access: a RAM access following DONE proceeds without stall, and sel_q returns to 0.
- Reset mid-REQ: pb_req_o drops immediately. The pending transfer is abandoned; peripherals must tolerate this.

Optional Feature:
- Macro DMEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to REQ and increments each REQ cycle without ack.
  - When counter = TIMEOUT_CYC and still no ack: drop pb_req_o, rdata_q ← 32'h0000_0000, err_o = 1 for one cycle, go to DONE.
  - If ack arrives in the same cycle as the timeout, ack wins and err_o stays 0.
- Undefined: no counter; waits indefinitely; err_o = 0.

Decomposition:
- Shared package / defines header:
  - FSM state encodings (IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2).
  - Region-select bit index (31).
  - Timeout error read value.
- Natural sub-module: pb_timeout_cnt, containing the counter and the compare. It is instantiated only under DMEM_BRIDGE_TIMEOUT_EN.

Test Plan:
- RAM store then load:
  - SW at addr 0x0000_0010, data 0x1234_5678 → ram_we_o = 4'b1111, ram_addr_o = 4, stall_o = 0.
  - Next-cycle load → rdata_o = ram_rdata_i.
- Peripheral read, ack 3 cycles after req:
  - addr 0x8000_0004, rd_i = 1, pb_rdata_i = 0xCAFE_0001.
  - stall_o high for 4 cycles, then DONE with stall_o = 0.
  - rdata_o = 0xCAFE_0001 in the following cycle; pb_we_o = 0.
- Peripheral byte store:
  - addr 0x8000_0003, wr_en_i = 4'b0001 → pb_be_o = 4'b0001, pb_we_o = 1, ram_we_o = 0 throughout.
  - No re-request in DONE.
- Stale ack: pulse pb_ack_i while in IDLE → no state change, stall_o = 0, rdata_q unchanged.
- Reset during REQ: rst low while pb_req_o = 1 → pb_req_o = 0, stall_o = 0 and state = IDLE immediately (asynchronous).
- Timeout (DMEM_BRIDGE_TIMEOUT_EN defined, TIMEOUT_CYC = 4):
  - Never ack → err_o pulses exactly once, then DONE.
  - rdata_o = 0 the next cycle; pb_req_o low.

Source files
------------

// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and constants for the data-memory bus bridge.
// Optional timeout support is selected with DMEM_BRIDGE_TIMEOUT_EN.
package dmem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned SEL_BIT   = 31;
    localparam logic [31:0] TMO_RDATA = 32'h0000_0000;

    function automatic logic is_pacc(
        input logic [31:0] addr,
        input logic        rd,
        input logic [3:0]  we
    );
        return addr[SEL_BIT] & (rd | (|we));
    endfunction

endpackage

// File: rtl/dmem_bus_bridge_pb_timeout_cnt.sv
// Peripheral-bus wait counter with expiry compare.
// Instantiated only when DMEM_BRIDGE_TIMEOUT_EN is defined.
module pb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/dmem_bus_bridge.sv
// Routes data-memory accesses to on-chip RAM or a req/ack peripheral bus.
// Define DMEM_BRIDGE_TIMEOUT_EN to abort peripheral accesses that never ack.
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int unsigned RAM_AW      = 12,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wr_en_i,
    input  logic              rd_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [3:0]        ram_we_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic              pb_req_o,
    output logic              pb_we_o,
    output logic [31:0]       pb_addr_o,
    output logic [3:0]        pb_be_o,
    output logic [31:0]       pb_wdata_o,
    input  logic [31:0]       pb_rdata_i,
    input  logic              pb_ack_i,
    output logic              err_o
);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_cnt_w_chk
        $error("CNT_W too narrow for TIMEOUT_CYC");
    end

    state_e      state_q;
    logic        pb_req_q;
    logic        pb_we_q;
    logic [31:0] pb_addr_q;
    logic [3:0]  pb_be_q;
    logic [31:0] pb_wdata_q;
    logic [31:0] rdata_q;
    logic        sel_q;
    logic        err_q;
    logic        pacc_w;
    logic        stall_w;
    logic        tmo_w;

    assign pacc_w = is_pacc(addr_i, rd_i, wr_en_i);

    always_comb begin
        stall_w = 1'b0;
        unique case (state_q)
            IDLE:    stall_w = pacc_w;
            REQ:     stall_w = 1'b1;
            default: stall_w = 1'b0;
        endcase
    end

    // Reset must release the pipeline at once, even with a held access.
    assign stall_o = rst & stall_w;

    assign ram_addr_o  = addr_i[RAM_AW+1:2];
    assign ram_wdata_o = wdata_i;
    assign ram_we_o    = (addr_i[SEL_BIT] | stall_o | (state_q == DONE))
                       ? 4'b0000 : wr_en_i;

    assign rdata_o = sel_q ? rdata_q : ram_rdata_i;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    pb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == IDLE),
        .inc_i     ((state_q == REQ) && !pb_ack_i),
        .expired_o (tmo_w)
    );
`else
    assign tmo_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= 1'b0;
        end else if (!stall_o) begin
            sel_q <= addr_i[SEL_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pb_req_q   <= 1'b0;
            pb_we_q    <= 1'b0;
            pb_addr_q  <= '0;
            pb_be_q    <= '0;
            pb_wdata_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pacc_w) begin
                        pb_addr_q  <= addr_i;
                        pb_be_q    <= wr_en_i;
                        pb_wdata_q <= wdata_i;
                        pb_we_q    <= |wr_en_i;
                        pb_req_q   <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    // A late ack still beats an expiring timeout.
                    if (pb_ack_i) begin
                        rdata_q  <= pb_rdata_i;
                        pb_req_q <= 1'b0;
                        state_q  <= DONE;
                    end else if (tmo_w) begin
                        rdata_q  <= TMO_RDATA;
                        pb_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    pb_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign pb_req_o   = pb_req_q;
    assign pb_we_o    = pb_we_q;
    assign pb_addr_o  = pb_addr_q;
    assign pb_be_o    = pb_be_q;
    assign pb_wdata_o = pb_wdata_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomised bench for dmem_bus_bridge with a RAM model and an expected-memory model.
// Timeout scenarios run when DMEM_BRIDGE_TIMEOUT_EN is defined.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wr_en_i = '0;
    logic        rd_i = 1'b0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic [11:0] ram_addr_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;
    logic        pb_req_o;
    logic        pb_we_o;
    logic [31:0] pb_addr_o;
    logic [3:0]  pb_be_o;
    logic [31:0] pb_wdata_o;
    logic [31:0] pb_rdata_i = '0;
    logic        pb_ack_i = 1'b0;
    logic        err_o;

    int total = 0;
    int bad = 0;
    logic [31:0] ram [0:4095];
    logic [31:0] exp_mem [0:15];
    logic [31:0] last_pb;

    dmem_bus_bridge #(
        .RAM_AW      (12),
        .TIMEOUT_CYC (4),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wr_en_i     (wr_en_i),
        .rd_i        (rd_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .pb_req_o    (pb_req_o),
        .pb_we_o     (pb_we_o),
        .pb_addr_o   (pb_addr_o),
        .pb_be_o     (pb_be_o),
        .pb_wdata_o  (pb_wdata_o),
        .pb_rdata_i  (pb_rdata_i),
        .pb_ack_i    (pb_ack_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read-first, one cycle latency.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we_o[b]) ram[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
        ram_rdata_i <= ram[ram_addr_o];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        addr_i   = '0;
        wdata_i  = '0;
        wr_en_i  = '0;
        rd_i     = 1'b0;
        pb_ack_i = 1'b0;
    endtask

    // Drives one peripheral access; ack is given in REQ cycle d (d<0: never).
    task automatic periph_access(
        input  logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
        input  logic rd, input int d, input logic [31:0] rdat,
        output int stalls, output logic [31:0] s_addr, output logic [3:0] s_be,
        output logic [31:0] s_wd, output logic s_we, output logic unstable,
        output logic ram_we_seen, output int errs, output logic req_after,
        output logic stall_after, output logic [31:0] rd_after, output logic hung
    );
        int reqs;
        logic done;
        reqs = 0; done = 1'b0; stalls = 0; errs = 0;
        unstable = 1'b0; ram_we_seen = 1'b0; hung = 1'b0;
        s_addr = '0; s_be = '0; s_wd = '0; s_we = 1'b0;
        addr_i = a; wr_en_i = be; wdata_i = wd; rd_i = rd;
        pb_rdata_i = rdat; pb_ack_i = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (err_o) errs++;
            if (|ram_we_o) ram_we_seen = 1'b1;
            if (pb_req_o) begin
                if (reqs == 0) begin
                    s_addr = pb_addr_o; s_be = pb_be_o;
                    s_wd = pb_wdata_o; s_we = pb_we_o;
                end else if (pb_addr_o != s_addr || pb_be_o != s_be ||
                             pb_wdata_o != s_wd || pb_we_o != s_we) begin
                    unstable = 1'b1;
                end
                if (reqs == d) pb_ack_i = 1'b1;
                reqs++;
            end
            if (stall_o) stalls++;
            else if (stalls > 0) done = 1'b1;
            if (!done) begin
                tick();
                pb_ack_i = 1'b0;
            end
        end
        if (!done) hung = 1'b1;
        tick();
        pb_ack_i = 1'b0;
        addr_i = 32'h0000_0014; wr_en_i = '0; wdata_i = '0; rd_i = 1'b1;
        @(negedge clk);
        if (err_o) errs++;
        req_after = pb_req_o;
        stall_after = stall_o;
        rd_after = rdata_o;
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        #3;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall_o); end
        total++; if (pb_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", pb_req_o); end
        total++; if ({pb_we_o, pb_addr_o, pb_be_o, pb_wdata_o} !== 69'd0) begin
            bad++; $display("FAIL rst_pb_fields got=%0h/%0h/%0h/%0h exp=0", pb_we_o, pb_addr_o, pb_be_o, pb_wdata_o);
        end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h exp=0", err_o); end
        total++; if (rdata_o !== ram_rdata_i) begin bad++; $display("FAIL rst_rdata got=%0h exp=%0h", rdata_o, ram_rdata_i); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ram_store_load();
        addr_i = 32'h0000_0010; wdata_i = 32'h1234_5678; wr_en_i = 4'b1111; rd_i = 1'b0;
        @(negedge clk);
        total++; if (ram_we_o !== 4'b1111) begin bad++; $display("FAIL sw_we got=%0h exp=f", ram_we_o); end
        total++; if (ram_addr_o !== 12'd4) begin bad++; $display("FAIL sw_addr got=%0h exp=4", ram_addr_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL sw_stall got=%0h exp=0", stall_o); end
        total++; if (ram_wdata_o !== 32'h1234_5678) begin bad++; $display("FAIL sw_wdata got=%0h exp=12345678", ram_wdata_o); end
        exp_mem[4] = 32'h1234_5678;
        tick();
        wr_en_i = 4'b0000; rd_i = 1'b1;
        tick();
        drive_idle();
        @(negedge clk);
        total++; if (rdata_o !== 32'h1234_5678) begin bad++; $display("FAIL lw_rdata got=%0h exp=12345678", rdata_o); end
        tick();
    endtask

    task automatic test_ram_random();
        int op;
        int w;
        logic [3:0] be;
        logic [31:0] wd;
        logic [31:0] pend;
        logic pend_v;
        pend_v = 1'b0; pend = '0;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            w = $urandom_range(0, 15);
            wd = $urandom;
            be = (op == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            addr_i = {1'b0, 17'($urandom), 8'h00, 4'(w), 2'($urandom)};
            wdata_i = wd; wr_en_i = be; rd_i = (op == 1);
            @(negedge clk);
            total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL ram_stall got=%0h exp=0", stall_o); end
            total++; if (ram_addr_o !== 12'(w)) begin bad++; $display("FAIL ram_addr got=%0h exp=%0h", ram_addr_o, w); end
            total++; if (ram_we_o !== be) begin bad++; $display("FAIL ram_we got=%0h exp=%0h", ram_we_o, be); end
            total++; if (ram_wdata_o !== wd) begin bad++; $display("FAIL ram_wdata got=%0h exp=%0h", ram_wdata_o, wd); end
            if (pend_v) begin
                total++; if (rdata_o !== pend) begin bad++; $display("FAIL ram_rdata got=%0h exp=%0h", rdata_o, pend); end
            end
            for (int b = 0; b < 4; b++) begin
                if (be[b]) exp_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
            pend_v = (op == 1);
            pend = exp_mem[w];
            tick();
        end
        drive_idle();
        @(negedge clk);
        if (pend_v) begin
            total++; if (rdata_o !== pend) begin bad++; $display("FAIL ram_rdata_last got=%0h exp=%0h", rdata_o, pend); end
        end
        tick();
    endtask

    task automatic test_periph_read();
        int st, er;
        logic [31:0] sa, sw, ra;
        logic [3:0] sb;
        logic swe, uns, rwe, rq, sta, hg;
        periph_access(32'h8000_0004, 4'b0000, 32'h0, 1'b1, 2, 32'hCAFE_0001,
                      st, sa, sb, sw, swe, uns, rwe, er, rq, sta, ra, hg);
        total++; if (hg) begin bad++; $display("FAIL prd_bound got=hung exp=done"); end
        total++; if (st != 4) begin bad++; $display("FAIL prd_stalls got=%0d exp=4", st); end
        total++; if (swe !== 1'b0) begin bad++; $display("FAIL prd_we got=%0h exp=0", swe); end
        total++; if (sa !== 32'h8000_0004) begin bad++; $display("FAIL prd_addr got=%0h exp=80000004", sa); end
        total++; if (ra !== 32'hCAFE_0001) begin bad++; $display("FAIL prd_rdata got=%0h exp=cafe0001", ra); end
        total++; if (rq !== 1'b0) begin bad++; $display("FAIL prd_rereq got=%0h exp=0", rq); end
        total++; if (er != 0) begin bad++; $display("FAIL prd_err got=%0d exp=0", er); end
        last_pb = 32'hCAFE_0001;
        drive_idle();
    endtask

    task automatic test_periph_store();
        int st, er, d;
        logic [31:0] sa, sw, ra, rdat;
        logic [3:0] sb;
        logic swe, uns, rwe, rq, sta, hg;
        d = $urandom_range(0, 5);
        rdat = $urandom;
        periph_access(32'h8000_0003, 4'b0001, 32'hA5A5_A5A5, 1'b0, d, rdat,
                      st, sa, sb, sw, swe, uns, rwe, er, rq, sta, ra, hg);
        total++; if (hg) begin bad++; $display("FAIL pst_bound got=hung exp=done"); end
        total++; if (sb !== 4'b0001) begin bad++; $display("FAIL pst_be got=%0h exp=1", sb); end
        total++; if (swe !== 1'b1) begin bad++; $display("FAIL pst_we got=%0h exp=1", swe); end
        total++; if (sw !== 32'hA5A5_A5A5) begin bad++; $display("FAIL pst_wdata got=%0h exp=a5a5a5a5", sw); end
        total++; if (rwe !== 1'b0) begin bad++; $display("FAIL pst_ramwe got=%0h exp=0", rwe); end
        total++; if (rq !== 1'b0) begin bad++; $display("FAIL pst_rereq got=%0h exp=0", rq); end
        total++; if (st != d + 2) begin bad++; $display("FAIL pst_stalls got=%0d exp=%0d", st, d + 2); end
        total++; if (ra !== rdat) begin bad++; $display("FAIL pst_rdata got=%0h exp=%0h", ra, rdat); end
        last_pb = rdat;
        drive_idle();
    endtask

    task automatic test_periph_random();
        int st, er, d;
        logic [31:0] a, wd, rdat, sa, sw, ra;
        logic [3:0] be, sb;
        logic rd, swe, uns, rwe, rq, sta, hg;
        for (int i = 0; i < 20; i++) begin
            a = {1'b1, 31'($urandom)};
            rd = $urandom_range(0, 1);
            be = rd ? 4'b0000 : 4'($urandom_range(1, 15));
            wd = $urandom; rdat = $urandom;
            d = $urandom_range(0, 6);
            periph_access(a, be, wd, rd, d, rdat,
                          st, sa, sb, sw, swe, uns, rwe, er, rq, sta, ra, hg);
            total++; if (hg) begin bad++; $display("FAIL prnd_bound got=hung exp=done"); end
            total++; if (st != d + 2) begin bad++; $display("FAIL prnd_stalls got=%0d exp=%0d", st, d + 2); end
            total++; if ({sa, sb, sw, swe} !== {a, be, wd, |be}) begin
                bad++; $display("FAIL prnd_fields got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", sa, sb, sw, swe, a, be, wd, |be);
            end
            total++; if (uns !== 1'b0) begin bad++; $display("FAIL prnd_stable got=%0h exp=0", uns); end
            total++; if (ra !== rdat) begin bad++; $display("FAIL prnd_rdata got=%0h exp=%0h", ra, rdat); end
            total++; if (rwe !== 1'b0 || rq !== 1'b0 || er != 0) begin
                bad++; $display("FAIL prnd_side got=%0h/%0h/%0d exp=0/0/0", rwe, rq, er);
            end
            last_pb = rdat;
        end
        drive_idle();
    endtask

    task automatic test_mixed();
        int st, er;
        logic [31:0] sa, sw, ra;
        logic [3:0] sb;
        logic swe, uns, rwe, rq, sta, hg;
        periph_access(32'h8000_0100, 4'b0000, 32'h0, 1'b1, $urandom_range(0, 3), 32'h5EED_0001,
                      st, sa, sb, sw, swe, uns, rwe, er, rq, sta, ra, hg);
        last_pb = 32'h5EED_0001;
        total++; if (sta !== 1'b0) begin bad++; $display("FAIL mix_stall got=%0h exp=0", sta); end
        total++; if (ra !== 32'h5EED_0001) begin bad++; $display("FAIL mix_prdata got=%0h exp=5eed0001", ra); end
        drive_idle();
        @(negedge clk);
        total++; if (rdata_o !== exp_mem[5]) begin bad++; $display("FAIL mix_ramrdata got=%0h exp=%0h", rdata_o, exp_mem[5]); end
        tick();
    endtask

    task automatic test_stale_ack();
        drive_idle();
        pb_ack_i = 1'b1; pb_rdata_i = ~last_pb;
        @(negedge clk);
        total++; if (stall_o !== 1'b0 || pb_req_o !== 1'b0) begin
            bad++; $display("FAIL stale_state got=%0h/%0h exp=0/0", stall_o, pb_req_o);
        end
        tick();
        pb_ack_i = 1'b0;
        addr_i = 32'h8000_0000;
        @(negedge clk);
        total++; if (stall_o !== 1'b0 || pb_req_o !== 1'b0) begin
            bad++; $display("FAIL stale_noacc got=%0h/%0h exp=0/0", stall_o, pb_req_o);
        end
        tick();
        drive_idle();
        @(negedge clk);
        total++; if (rdata_o !== last_pb) begin bad++; $display("FAIL stale_rdata got=%0h exp=%0h", rdata_o, last_pb); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [0:3];
        int acc;
        logic exp_st;
        acc = 0;
        for (int i = 0; i < 4; i++) data[i] = 32'hB000_0000 | 32'($urandom_range(0, 65535));
        addr_i = 32'h8000_0010; rd_i = 1'b1; wr_en_i = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_st = (k % 3) != 2;
            total++; if (stall_o !== exp_st) begin bad++; $display("FAIL b2b_stall k=%0d got=%0h exp=%0h", k, stall_o, exp_st); end
            if (k > 0 && k % 3 == 0) begin
                total++; if (rdata_o !== data[k/3 - 1]) begin
                    bad++; $display("FAIL b2b_rdata k=%0d got=%0h exp=%0h", k, rdata_o, data[k/3 - 1]);
                end
            end
            if (pb_req_o && acc < 4) begin
                pb_rdata_i = data[acc];
                pb_ack_i = 1'b1;
                acc++;
            end
            tick();
            pb_ack_i = 1'b0;
        end
        drive_idle();
        @(negedge clk);
        total++; if (rdata_o !== data[3]) begin bad++; $display("FAIL b2b_last got=%0h exp=%0h", rdata_o, data[3]); end
        total++; if (acc != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", acc); end
        last_pb = data[3];
        tick();
    endtask

    task automatic test_reset_mid_req();
        int st, er;
        logic [31:0] sa, sw, ra;
        logic [3:0] sb;
        logic swe, uns, rwe, rq, sta, hg, seen;
        seen = 1'b0;
        addr_i = 32'h8000_0040; rd_i = 1'b1; wr_en_i = '0; pb_ack_i = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (pb_req_o) seen = 1'b1;
            else tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL rmid_req got=0 exp=1"); end
        rst = 1'b0;
        #1;
        total++; if (pb_req_o !== 1'b0) begin bad++; $display("FAIL rmid_req_drop got=%0h exp=0", pb_req_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%0h exp=0", stall_o); end
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        tick();
        periph_access(32'h8000_0044, 4'b0000, 32'h0, 1'b1, 1, 32'h0BAD_F00D,
                      st, sa, sb, sw, swe, uns, rwe, er, rq, sta, ra, hg);
        total++; if (st != 3) begin bad++; $display("FAIL rmid_idle_stalls got=%0d exp=3", st); end
        total++; if (ra !== 32'h0BAD_F00D) begin bad++; $display("FAIL rmid_rdata got=%0h exp=0badf00d", ra); end
        last_pb = 32'h0BAD_F00D;
        drive_idle();
    endtask

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int st, er;
        logic [31:0] sa, sw, ra;
        logic [3:0] sb;
        logic swe, uns, rwe, rq, sta, hg;
        periph_access(32'h8000_0200, 4'b0000, 32'h0, 1'b1, -1, 32'hDEAD_BEEF,
                      st, sa, sb, sw, swe, uns, rwe, er, rq, sta, ra, hg);
        total++; if (hg) begin bad++; $display("FAIL tmo_bound got=hung exp=done"); end
        total++; if (er != 1) begin bad++; $display("FAIL tmo_err got=%0d exp=1", er); end
        total++; if (st != 6) begin bad++; $display("FAIL tmo_stalls got=%0d exp=6", st); end
        total++; if (ra !== 32'h0) begin bad++; $display("FAIL tmo_rdata got=%0h exp=0", ra); end
        total++; if (rq !== 1'b0) begin bad++; $display("FAIL tmo_req got=%0h exp=0", rq); end
        periph_access(32'h8000_0204, 4'b0000, 32'h0, 1'b1, 4, 32'h1234_ABCD,
                      st, sa, sb, sw, swe, uns, rwe, er, rq, sta, ra, hg);
        total++; if (er != 0) begin bad++; $display("FAIL tmo_ackwin_err got=%0d exp=0", er); end
        total++; if (ra !== 32'h1234_ABCD) begin bad++; $display("FAIL tmo_ackwin_rdata got=%0h exp=1234abcd", ra); end
        drive_idle();
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = $urandom;
            ram[i] = exp_mem[i];
        end
        last_pb = '0;
        test_reset();
        test_ram_store_load();
        test_ram_random();
        test_periph_read();
        test_stale_ack();
        test_periph_store();
        test_periph_random();
        test_mixed();
        test_back_to_back();
        test_stale_ack();
        test_reset_mid_req();
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_ram_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
